propagation_timer: RTL
======================

// Module: propagation_timer
// PURPOSE
//  Measures the clock-cycle interval between a start pulse and a stop pulse.
//  Sits directly downstream of the two level-to-pulse converters on the
//  launch and receive paths of the propagation time meter.
//  Produces one result per measurement: a count with a valid strobe, or a
//  timeout strobe. Result is held for readout/display.
// PARAMETERS
//  CNT_WIDTH  16     width of interval counter and o_Count
//  TIMEOUT    65535  max measurable interval in cycles; legal 2..2^CNT_WIDTH-1
// PORTS
//  i_Clk      in   1          system clock, rising edge
//  i_Rst_n    in   1          asynchronous, active-low reset
//  i_Enable   in   1          1 = measurements allowed; 0 = abort/hold idle
//  i_Start    in   1          start pulse (launch edge), synchronous to i_Clk
//  i_Stop     in   1          stop pulse (receive edge), synchronous to i_Clk
//  o_Count    out  CNT_WIDTH  last measured interval in cycles (held)
//  o_Valid    out  1          1-cycle strobe: o_Count updated with a measurement
//  o_Timeout  out  1          1-cycle strobe: no stop within TIMEOUT cycles
//  o_Busy     out  1          1 while a measurement is in progress
// BEHAVIOUR
//  Reset (i_Rst_n=0, async): state=IDLE, internal cnt=0, o_Count=0,
//   o_Valid=0, o_Timeout=0, o_Busy=0. Reset mid-measurement aborts it, no strobe.
//  All outputs registered. o_Busy = (state==COUNT).
//  FSM states: IDLE, COUNT, DONE.
//  IDLE: i_Enable=1 & i_Start=1 at edge k -> COUNT, cnt<=0. i_Stop ignored,
//   including i_Stop=1 in the same cycle as i_Start (zero-length interval not
//   measurable).
//  COUNT, at each edge:
//   - i_Enable=0 -> IDLE. No strobe. o_Count unchanged.
//   - i_Stop=1 -> o_Count<=cnt+1, o_Valid<=1, go to DONE.
//   - i_Stop=0 & cnt+1==TIMEOUT -> o_Count<=TIMEOUT, o_Timeout<=1, go to DONE.
//   - otherwise cnt<=cnt+1.
//   - i_Start is ignored in COUNT (no restart).
//  Result definition: start sampled at edge k and stop at edge k+N gives
//   o_Count=N (1<=N<=TIMEOUT). Stop at edge k+TIMEOUT gives o_Valid with
//   count TIMEOUT. The stop wins over the timeout on the same edge.
//  DONE: lasts exactly 1 cycle, with o_Valid or o_Timeout high during it.
//   Next edge -> IDLE and the strobe clears. i_Start in DONE is ignored
//   (1-cycle holdoff).
//  Throughput: next start accepted at the earliest 2 edges after the stop edge.
//  Arithmetic: cnt is CNT_WIDTH bits and never exceeds TIMEOUT-1, so no wrap.
//  o_Valid and o_Timeout are never high together.
//  i_Enable=0 in IDLE or DONE: DONE still completes its strobe; starts ignored.
// TESTING
//  1 Assert i_Rst_n=0 mid-run -> all outputs 0 immediately; release -> IDLE,
//    o_Busy=0.
//  2 Start at edge k, stop at edge k+5 -> o_Busy=1 for 5 cycles; o_Valid=1
//    for 1 cycle; o_Count=5; then o_Count holds 5.
//  3 Start at k, stop at k+1 -> o_Count=1. Start+stop in the same cycle,
//    then stop at +3 -> o_Count=3.
//  4 TIMEOUT=20, no stop -> o_Timeout=1 for 1 cycle, 20 edges after start;
//    o_Count=20; o_Valid=0. Stop at exactly +20 -> o_Valid=1, o_Count=20,
//    o_Timeout=0.
//  5 Stop while IDLE -> no change. Second start at +2 during COUNT, stop at
//    +7 -> o_Count=7. Start during DONE -> ignored, o_Busy stays 0.
//  6 i_Enable=0 at +3 during COUNT -> IDLE, no strobe, o_Count keeps its
//    prior value; re-enable, start/stop 4 apart -> o_Count=4.

Source files
------------

// File: rtl/propagation_timer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : propagation_timer_if
// Brief    : Control/result bundle between the pulse converters and the timer.
// Revision : 1.0
// ============================================================================
interface propagation_timer_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 i_Enable;
   logic                 i_Start;
   logic                 i_Stop;
   logic [CNT_WIDTH-1:0] o_Count;
   logic                 o_Valid;
   logic                 o_Timeout;
   logic                 o_Busy;

   modport master (
      output i_Enable, i_Start, i_Stop,
      input  o_Count, o_Valid, o_Timeout, o_Busy
   );

   modport slave (
      input  i_Enable, i_Start, i_Stop,
      output o_Count, o_Valid, o_Timeout, o_Busy
   );
endinterface
`default_nettype wire

// File: rtl/propagation_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : propagation_timer
// Brief    : Counts clock cycles from a start pulse to a stop pulse, with timeout.
// Revision : 1.0
// ============================================================================
module propagation_timer #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 65535
) (
   input  wire logic          i_Clk,
   input  wire logic          i_Rst_n,
   propagation_timer_if.slave tmr
);
   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_COUNT = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   localparam logic [CNT_WIDTH-1:0] c_TIMEOUT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);

   logic [1:0]           r_state;
   logic [1:0]           w_next_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_next;
   logic [CNT_WIDTH-1:0] w_cnt_inc;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] w_count_next;
   logic                 r_valid;
   logic                 w_valid_next;
   logic                 r_timeout;
   logic                 w_timeout_next;
   logic                 r_busy;
   logic                 w_accept_start;
   logic                 w_hit_stop;
   logic                 w_hit_timeout;

   // cnt never exceeds TIMEOUT-1, so the increment cannot wrap.
   assign w_cnt_inc      = r_cnt + c_ONE;
   assign w_accept_start = tmr.i_Enable & tmr.i_Start;
   assign w_hit_stop     = tmr.i_Enable & tmr.i_Stop;
   assign w_hit_timeout  = tmr.i_Enable & ~tmr.i_Stop & (w_cnt_inc == c_TIMEOUT);

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_accept_start) begin
               w_next_state = c_COUNT;
            end
         end
         c_COUNT: begin
            if (!tmr.i_Enable) begin
               w_next_state = c_IDLE;
            end else if (w_hit_stop || w_hit_timeout) begin
               w_next_state = c_DONE;
            end
         end
         c_DONE: begin
            w_next_state = c_IDLE;
         end
         default: begin
            w_next_state = c_IDLE;
         end
      endcase
   end

   // Stop takes priority over timeout when both land on the same edge.
   always_comb begin
      w_cnt_next     = r_cnt;
      w_count_next   = r_count;
      w_valid_next   = 1'b0;
      w_timeout_next = 1'b0;
      case (r_state)
         c_IDLE: begin
            if (w_accept_start) begin
               w_cnt_next = '0;
            end
         end
         c_COUNT: begin
            if (!tmr.i_Enable) begin
               w_cnt_next = r_cnt;
            end else if (w_hit_stop) begin
               w_count_next = w_cnt_inc;
               w_valid_next = 1'b1;
            end else if (w_hit_timeout) begin
               w_count_next   = c_TIMEOUT;
               w_timeout_next = 1'b1;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         default: begin
            w_cnt_next = r_cnt;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_cnt     <= '0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_next;
         r_count   <= w_count_next;
         r_valid   <= w_valid_next;
         r_timeout <= w_timeout_next;
         r_busy    <= (w_next_state == c_COUNT);
      end
   end

   assign tmr.o_Count   = r_count;
   assign tmr.o_Valid   = r_valid;
   assign tmr.o_Timeout = r_timeout;
   assign tmr.o_Busy    = r_busy;
endmodule
`default_nettype wire
